wave_gen_multi: RTL

WAVE_GEN_MULTI -- requirements
Module: wave_gen_multi

---
 rtl/wave_gen_multi.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wave_gen_multi.sv
// Multi-channel DDS waveform generator. Each channel's config is written to a
// shadow copy and only takes effect on its accumulator wrap, keeping periods whole.
module wave_gen_multi #(
  parameter int NUM_CH  = 2,
  parameter int OUT_W   = 8,
  parameter int PHASE_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [2:0]              cfg_ch,
  input  logic [1:0]              cfg_addr,
  input  logic [PHASE_W-1:0]      cfg_data,
  input  logic                    sync,
  output logic [NUM_CH*OUT_W-1:0] wave_out,
  output logic [NUM_CH-1:0]       wrap_out
);

  typedef enum logic [1:0] {MODE_SAW, MODE_TRI, MODE_PULSE, MODE_SQUARE} mode_e;
  typedef enum logic [1:0] {ADDR_FREQ, ADDR_DUTY, ADDR_OFFSET, ADDR_CTRL} addr_e;

  typedef struct packed {
    logic       restart;
    logic       enable;
    logic [1:0] amp_shift;
    mode_e      mode;
  } ctrl_t;

  localparam logic signed [OUT_W-1:0] POS_PEAK = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] NEG_PEAK = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

  logic [NUM_CH-1:0] pending;
  logic [7:0]        pending_pad;
  logic              ch_valid;

  // Pad to the full 3-bit channel space so any cfg_ch indexes safely.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pending_pad = '0;
    pending_pad[NUM_CH-1:0] = pending;
  end

  assign ch_valid  = ({1'b0, cfg_ch} < 4'(NUM_CH));
  assign cfg_ready = !ch_valid || !pending_pad[cfg_ch];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PHASE_W-1:0]      sh_freq, sh_duty, sh_off;
    logic [PHASE_W-1:0]      act_freq, act_duty, act_off;
    logic [PHASE_W-1:0]      acc, phase;
    ctrl_t                   sh_ctrl, act_ctrl;
    logic                    pend, accept, carry, commit, wrap_q;
    logic [PHASE_W:0]        sum;
    logic [OUT_W-1:0]        t;
    logic [OUT_W-2:0]        tri_f;
    logic signed [OUT_W-1:0] raw, wave_q;

    assign accept = cfg_valid && (cfg_ch == 3'(k)) && !pend;
    assign sum    = {1'b0, acc} + {1'b0, act_freq};
    assign carry  = act_ctrl.enable && sum[PHASE_W];
    // A disabled channel never wraps, so it commits on the first edge after pending.
    assign commit = pend && (carry || !act_ctrl.enable);

    always_comb begin
      phase = acc + act_off;
      t     = phase[PHASE_W-1 -: OUT_W];
      tri_f = t[OUT_W-2:0] ^ {(OUT_W-1){t[OUT_W-1]}};
      raw   = '0;
      unique case (act_ctrl.mode)
        MODE_SAW:    raw = {~t[OUT_W-1], t[OUT_W-2:0]};
        // 2f - M: doubling is a left shift, subtracting M flips the MSB.
        MODE_TRI:    raw = {~tri_f[OUT_W-2], tri_f[OUT_W-3:0], 1'b0};
        MODE_PULSE:  raw = (phase < act_duty) ? POS_PEAK : NEG_PEAK;
        MODE_SQUARE: raw = t[OUT_W-1] ? NEG_PEAK : POS_PEAK;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_freq  <= '0;
        sh_duty  <= '0;
        sh_off   <= '0;
        sh_ctrl  <= '0;
        act_freq <= '0;
        act_duty <= '0;
        act_off  <= '0;
        act_ctrl <= '0;
        acc      <= '0;
        pend     <= 1'b0;
        wrap_q   <= 1'b0;
        wave_q   <= '0;
      end else begin
        if (accept) begin
          unique case (addr_e'(cfg_addr))
            ADDR_FREQ:   sh_freq <= cfg_data;
            ADDR_DUTY:   sh_duty <= cfg_data;
            ADDR_OFFSET: sh_off  <= cfg_data;
            ADDR_CTRL: begin
              sh_ctrl <= ctrl_t'(cfg_data[5:0]);
              pend    <= 1'b1;
            end
          endcase
        end
        if (commit) begin
          act_freq <= sh_freq;
          act_duty <= sh_duty;
          act_off  <= sh_off;
          act_ctrl <= sh_ctrl;
          pend     <= 1'b0;
        end

        if (act_ctrl.enable && sync)       acc <= '0;
        else if (commit && sh_ctrl.restart) acc <= '0;
        else if (act_ctrl.enable)          acc <= sum[PHASE_W-1:0];

        wrap_q <= carry;
        if (act_ctrl.enable) wave_q <= raw >>> act_ctrl.amp_shift;
        else                 wave_q <= '0;
      end
    end

    assign pending[k]                   = pend;
    assign wrap_out[k]                  = wrap_q;
    assign wave_out[k*OUT_W +: OUT_W]   = wave_q;
  end

endmodule
